mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Memory-side end of the CPU memory bus: accepts CPU accesses on address/data_out, returns read data on data_in.
//  Serves internal RAM directly; forwards accesses in the external window over a req/ack handshake.
//  Signals completion with a one-cycle ready pulse. Sits between the CPU core and off-chip memory/IO.
// PARAMETERS
//  RAM_AW       11        internal RAM address bits; RAM occupies 0x0000 .. 2**RAM_AW-1
//  WAIT_STATES  0         extra cycles inserted before an internal-RAM access completes (0..15)
//  EXT_BASE     16'h8000  first address of external window (window runs EXT_BASE..0xFFFF)
//  TIMEOUT      16        cycles to wait for ext_ack before aborting (>=2)
// PORTS
//  ph2        in   1   single clock; all state updates on rising edge
//  resetb     in   1   synchronous active-low reset
//  address    in   16  CPU access address, sampled in the accept cycle
//  data_out   in   8   CPU write data, sampled in the accept cycle
//  memwrite   in   1   1 = write, 0 = read; sampled in the accept cycle
//  mem_req    in   1   access request; accepted only in IDLE
//  data_in    out  8   read data to CPU; valid while ready=1, held until next read completes
//  ready      out  1   one-cycle completion pulse
//  ext_req    out  1   external handshake request, held until ack or timeout
//  ext_we     out  1   external write enable, stable while ext_req=1
//  ext_addr   out  16  external address, stable while ext_req=1
//  ext_wdata  out  8   external write data, stable while ext_req=1
//  ext_rdata  in   8   external read data, sampled in the cycle ext_ack=1
//  ext_ack    in   1   external acknowledge
//  bus_error  out  1   one-cycle error pulse (present only with MEM_BUS_RESP_ERR_EN)
// BEHAVIOUR
//  Reset (resetb=0 at edge): state IDLE; data_in=8'h00, ready=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, bus_error=0.
//  FSM states: IDLE, RAM_WAIT, EXT_REQ, RESP.
//  IDLE: mem_req=1 latches address/data_out/memwrite; decode region:
//   RAM (addr < 2**RAM_AW): WAIT_STATES=0 -> RESP; else load wait counter, -> RAM_WAIT.
//   EXT (addr >= EXT_BASE): load timeout counter with TIMEOUT-1, drive ext_* next cycle, -> EXT_REQ.
//   Unmapped (otherwise): -> RESP with read data forced to 8'hFF, write discarded.
//  RAM_WAIT: decrement counter; at 0 -> RESP. Latency accept->ready = 1+WAIT_STATES cycles.
//  RAM write commits on the edge entering RESP; RAM read data presented on data_in in RESP.
//  EXT_REQ: ext_req=1 every cycle in state. ext_ack=1: capture ext_rdata (reads), drop ext_req next cycle, -> RESP.
//   Counter reaches 0 with no ack: drop ext_req, data_in=8'hFF (reads), -> RESP (timeout).
//   ext_ack while not in EXT_REQ is ignored. Min ext latency accept->ready = 3 cycles (ack on first req cycle).
//  RESP: ready=1 for exactly one cycle, -> IDLE. mem_req during RESP is ignored (not queued).
//  mem_req while busy (RAM_WAIT/EXT_REQ/RESP): ignored; CPU must hold or re-issue after ready.
//  data_in updated only on read completion; writes leave data_in unchanged.
//  Reset mid-access: aborts immediately; no RAM write, ext_req low after the reset edge, no ready pulse.
//  Address compare is unsigned 16-bit; RAM index = address[RAM_AW-1:0]. EXT_BASE must exceed 2**RAM_AW-1.
// CONFIGURATION
//  MEM_BUS_RESP_ERR_EN defined: bus_error pulses in RESP for unmapped access or ext timeout (same cycle as ready).
//  MEM_BUS_RESP_ERR_EN undefined: bus_error port absent; unmapped/timeout behave identically otherwise (8'hFF, ready).
// STRUCTURE
//  Package mem_bus_pkg: state enum (IDLE,RAM_WAIT,EXT_REQ,RESP), region enum (REG_RAM,REG_EXT,REG_NONE),
//   constant BUS_FILL=8'hFF, decode function region_of(addr,RAM_AW,EXT_BASE).
//  Sub-module mem_bus_ram: synchronous single-port 2**RAM_AW x 8 RAM, write-enable, registered read.
//  Top holds FSM, request latch, wait/timeout counter, ext output registers, data_in register.
// TESTING
//  RAM write 0x0123<=0x5A then read 0x0123, WAIT_STATES=0 -> ready 1 cycle after each accept, data_in=0x5A.
//  WAIT_STATES=3, read 0x0010 -> ready exactly 4 cycles after accept; mem_req pulses meanwhile ignored.
//  Ext read 0x9000, ack 2 cycles after ext_req rises with ext_rdata=0xC3 -> ext_addr=0x9000, data_in=0xC3, ext_req low after ack.
//  Ext write 0xFFFC<=0x11, never ack, TIMEOUT=16 -> ext_req high 16 cycles, ready pulses, data_in unchanged, bus_error=1 (ERR_EN).
//  Read unmapped 0x4000 -> ready after 1 cycle, data_in=0xFF, bus_error=1 with ERR_EN, port absent without.
//  resetb=0 during EXT_REQ and during RAM write with WAIT_STATES=2 -> ext_req=0, no ready, RAM location unchanged.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state/region types, fill value and address decode for mem_bus_responder.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        EXT_REQ,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_EXT,
        REG_NONE
    } region_e;

    // What the RESP cycle has to present alongside ready.
    typedef enum logic [1:0] {
        RK_NONE,
        RK_RAM_RD,
        RK_ERR
    } resp_e;

    localparam logic [7:0] BUS_FILL = 8'hFF;

    function automatic region_e region_of(input logic [15:0] addr,
                                          input int unsigned ram_aw,
                                          input logic [15:0] ext_base);
        logic [16:0] ram_end;
        ram_end = 17'd1 << ram_aw;
        if ({1'b0, addr} < ram_end) return REG_RAM;
        if (addr >= ext_base) return REG_EXT;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// mem_bus_ram: single-port 2**RAM_AW x 8 synchronous RAM with write enable and registered read.
module mem_bus_ram
    import mem_bus_pkg::*;
#(
    parameter int unsigned RAM_AW = 11
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [0:(1 << RAM_AW) - 1];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side end of the CPU bus; internal RAM plus req/ack external window.
// Optional MEM_BUS_RESP_ERR_EN adds the bus_error pulse for unmapped accesses and ext timeouts.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned RAM_AW      = 11,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] EXT_BASE    = 16'h8000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        ph2,
    input  logic        resetb,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    input  logic        memwrite,
    input  logic        mem_req,
    output logic [7:0]  data_in,
    output logic        ready,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
`ifdef MEM_BUS_RESP_ERR_EN
    ,
    output logic        bus_error
`endif
);

    localparam logic [15:0] WAIT_LOAD = 16'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic [15:0] TO_LOAD   = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    resp_e               resp_q, resp_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ext_req_q, ext_req_d;
    logic                ext_we_q, ext_we_d;
    logic [15:0]         ext_addr_q, ext_addr_d;
    logic [7:0]          ext_wdata_q, ext_wdata_d;
    logic [7:0]          data_in_q, data_in_d;
    logic [RAM_AW-1:0]   ram_idx_q, ram_idx_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                we_q, we_d;

    logic                ram_en, ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [7:0]          ram_wdata, ram_rdata;
    region_e             acc_region;

    assign acc_region = region_of(address, RAM_AW, EXT_BASE);

    mem_bus_ram #(.RAM_AW(RAM_AW)) u_ram (
        .clk_i   (ph2),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        cnt_d       = cnt_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        data_in_d   = data_in_q;
        ram_idx_d   = ram_idx_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = ram_idx_q;
        ram_wdata   = wdata_q;

        case (state_q)
            IDLE: begin
                // Zero-wait RAM accesses hit the array on the accept edge, so use the live bus.
                ram_addr  = address[RAM_AW-1:0];
                ram_wdata = data_out;
                if (mem_req) begin
                    ram_idx_d = address[RAM_AW-1:0];
                    wdata_d   = data_out;
                    we_d      = memwrite;
                    resp_d    = RK_NONE;
                    case (acc_region)
                        REG_RAM: begin
                            resp_d = memwrite ? RK_NONE : RK_RAM_RD;
                            if (WAIT_STATES == 0) begin
                                ram_en  = 1'b1;
                                ram_we  = memwrite;
                                state_d = RESP;
                            end else begin
                                cnt_d   = WAIT_LOAD;
                                state_d = RAM_WAIT;
                            end
                        end
                        REG_EXT: begin
                            cnt_d       = TO_LOAD;
                            ext_we_d    = memwrite;
                            ext_addr_d  = address;
                            ext_wdata_d = data_out;
                            state_d     = EXT_REQ;
                        end
                        default: begin
                            resp_d = RK_ERR;
                            if (!memwrite) data_in_d = BUS_FILL;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            RAM_WAIT: begin
                if (cnt_q == 16'd0) begin
                    ram_en  = 1'b1;
                    ram_we  = we_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            EXT_REQ: begin
                // First cycle in the state launches the request; ack counts only once it is visible.
                if (!ext_req_q) begin
                    ext_req_d = 1'b1;
                end else if (ext_ack) begin
                    if (!we_q) data_in_d = ext_rdata;
                    ext_req_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == 16'd0) begin
                    if (!we_q) data_in_d = BUS_FILL;
                    resp_d    = RK_ERR;
                    ext_req_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RESP: begin
                if (resp_q == RK_RAM_RD) data_in_d = ram_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!resetb) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge ph2) begin
        if (!resetb) begin
            state_q     <= IDLE;
            resp_q      <= RK_NONE;
            cnt_q       <= 16'd0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'd0;
            ext_wdata_q <= 8'd0;
            data_in_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            cnt_q       <= cnt_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            data_in_q   <= data_in_d;
        end
    end

    always_ff @(posedge ph2) begin
        ram_idx_q <= ram_idx_d;
        wdata_q   <= wdata_d;
        we_q      <= we_d;
    end

    // RAM read data comes straight from the array during RESP and is held in data_in_q after.
    assign data_in   = (state_q == RESP && resp_q == RK_RAM_RD) ? ram_rdata : data_in_q;
    assign ready     = (state_q == RESP);
    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

`ifdef MEM_BUS_RESP_ERR_EN
    assign bus_error = (state_q == RESP) && (resp_q == RK_ERR);
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed tests for mem_bus_responder at WAIT_STATES 0, 3 and 2.
module tb_mem_bus_responder;

    logic        ph2 = 1'b0;
    logic        resetb = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic        memwrite = 1'b0;
    logic        mem_req = 1'b0;
    logic [7:0]  ext_rdata = 8'h00;
    logic        ext_ack = 1'b0;

    // index 0: WAIT_STATES=0, 1: WAIT_STATES=3, 2: WAIT_STATES=2
    logic [7:0]  din   [3];
    logic        rdy   [3];
    logic        ereq  [3];
    logic        ewe   [3];
    logic [15:0] eaddr [3];
    logic [7:0]  ewd   [3];
`ifdef MEM_BUS_RESP_ERR_EN
    logic        berr  [3];
`endif

    int errors = 0;
    int checks = 0;

    always #5 ph2 = ~ph2;

    mem_bus_responder #(.RAM_AW(11), .WAIT_STATES(0), .EXT_BASE(16'h8000), .TIMEOUT(16)) dut (
        .ph2(ph2), .resetb(resetb), .address(address), .data_out(data_out),
        .memwrite(memwrite), .mem_req(mem_req), .data_in(din[0]), .ready(rdy[0]),
        .ext_req(ereq[0]), .ext_we(ewe[0]), .ext_addr(eaddr[0]), .ext_wdata(ewd[0]),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
`ifdef MEM_BUS_RESP_ERR_EN
        , .bus_error(berr[0])
`endif
    );

    mem_bus_responder #(.RAM_AW(11), .WAIT_STATES(3), .EXT_BASE(16'h8000), .TIMEOUT(16)) dut_w3 (
        .ph2(ph2), .resetb(resetb), .address(address), .data_out(data_out),
        .memwrite(memwrite), .mem_req(mem_req), .data_in(din[1]), .ready(rdy[1]),
        .ext_req(ereq[1]), .ext_we(ewe[1]), .ext_addr(eaddr[1]), .ext_wdata(ewd[1]),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
`ifdef MEM_BUS_RESP_ERR_EN
        , .bus_error(berr[1])
`endif
    );

    mem_bus_responder #(.RAM_AW(11), .WAIT_STATES(2), .EXT_BASE(16'h8000), .TIMEOUT(16)) dut_w2 (
        .ph2(ph2), .resetb(resetb), .address(address), .data_out(data_out),
        .memwrite(memwrite), .mem_req(mem_req), .data_in(din[2]), .ready(rdy[2]),
        .ext_req(ereq[2]), .ext_we(ewe[2]), .ext_addr(eaddr[2]), .ext_wdata(ewd[2]),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
`ifdef MEM_BUS_RESP_ERR_EN
        , .bus_error(berr[2])
`endif
    );

    task automatic step();
        @(posedge ph2);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] wd, input logic we);
        address  = a;
        data_out = wd;
        memwrite = we;
        mem_req  = 1'b1;
    endtask

    // Single access on the zero-wait instance: returns ready/data_in seen in the cycle after accept.
    task automatic access1(input logic [15:0] a, input logic [7:0] wd, input logic we,
                           output logic r, output logic [7:0] d);
        issue(a, wd, we);
        step();
        r = rdy[0];
        d = din[0];
        mem_req = 1'b0;
        step();
    endtask

    task automatic do_reset();
        resetb  = 1'b0;
        mem_req = 1'b0;
        ext_ack = 1'b0;
        step();
        step();
        resetb = 1'b1;
        step();
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        issue(16'h0123, 8'h77, 1'b1);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy[i] !== 1'b0 || ereq[i] !== 1'b0 || din[i] !== 8'h00 || eaddr[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state[%0d]: ready=%b ext_req=%b data_in=%h ext_addr=%h, want 0 0 00 0000",
                         i, rdy[i], ereq[i], din[i], eaddr[i]);
            end
        end
        checks++;
        if (ewe[0] !== 1'b0 || ewd[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_ext_we_wdata: got %b %h, want 0 00", ewe[0], ewd[0]);
        end
        mem_req = 1'b0;
        resetb  = 1'b1;
        step();
    endtask

    task automatic test_ram_rw();
        logic       r;
        logic [7:0] d;
        access1(16'h0123, 8'h5A, 1'b1, r, d);
        checks++;
        if (r !== 1'b1 || d !== 8'h00) begin
            errors++;
            $display("FAIL ram_write_resp: ready=%b data_in=%h, want 1 00", r, d);
        end
        checks++;
        if (rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ram_write_single_pulse: ready=%b, want 0", rdy[0]);
        end
        access1(16'h0123, 8'h00, 1'b0, r, d);
        checks++;
        if (r !== 1'b1 || d !== 8'h5A) begin
            errors++;
            $display("FAIL ram_read: ready=%b data_in=%h, want 1 5a", r, d);
        end
        checks++;
        if (din[0] !== 8'h5A) begin
            errors++;
            $display("FAIL ram_read_hold: data_in=%h, want 5a", din[0]);
        end
        access1(16'h07FF, 8'hA5, 1'b1, r, d);
        access1(16'h07FF, 8'h00, 1'b0, r, d);
        checks++;
        if (r !== 1'b1 || d !== 8'hA5) begin
            errors++;
            $display("FAIL ram_top_addr: ready=%b data_in=%h, want 1 a5", r, d);
        end
    endtask

    task automatic test_unmapped();
        logic       r;
        logic [7:0] d;
        issue(16'h4000, 8'h00, 1'b0);
        step();
        checks++;
        if (rdy[0] !== 1'b1 || din[0] !== 8'hFF) begin
            errors++;
            $display("FAIL unmapped_read: ready=%b data_in=%h, want 1 ff", rdy[0], din[0]);
        end
`ifdef MEM_BUS_RESP_ERR_EN
        checks++;
        if (berr[0] !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_bus_error: got %b, want 1", berr[0]);
        end
`endif
        mem_req = 1'b0;
        step();
        access1(16'h0123, 8'h00, 1'b0, r, d);
        access1(16'h4000, 8'h99, 1'b1, r, d);
        checks++;
        if (r !== 1'b1 || d !== 8'h5A) begin
            errors++;
            $display("FAIL unmapped_write_keeps_data: ready=%b data_in=%h, want 1 5a", r, d);
        end
        access1(16'h0800, 8'h00, 1'b0, r, d);
        checks++;
        if (r !== 1'b1 || d !== 8'hFF) begin
            errors++;
            $display("FAIL unmapped_low_edge_0800: ready=%b data_in=%h, want 1 ff", r, d);
        end
    endtask

    task automatic test_wait_states();
        logic [3:0] seen;
        logic       late;
        do_reset();
        issue(16'h0010, 8'h00, 1'b0);
        step();
        seen[0] = rdy[1];
        address = 16'h0020;
        step();
        seen[1] = rdy[1];
        mem_req = 1'b0;
        step();
        seen[2] = rdy[1];
        mem_req = 1'b1;
        step();
        seen[3] = rdy[1];
        checks++;
        if (seen !== 4'b1000) begin
            errors++;
            $display("FAIL wait3_latency: ready over cycles 4..1=%b, want 1000", seen);
        end
        step();
        mem_req = 1'b0;
        late = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rdy[1] !== 1'b0) late = 1'b1;
            step();
        end
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL wait3_req_ignored: extra ready=%b, want 0", late);
        end
    endtask

    task automatic test_ext_read();
        issue(16'h9000, 8'h00, 1'b0);
        step();
        mem_req = 1'b0;
        checks++;
        if (ereq[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ext_launch_cycle: ext_req=%b ready=%b, want 0 0", ereq[0], rdy[0]);
        end
        step();
        checks++;
        if (ereq[0] !== 1'b1 || eaddr[0] !== 16'h9000 || ewe[0] !== 1'b0) begin
            errors++;
            $display("FAIL ext_read_req: ext_req=%b ext_addr=%h ext_we=%b, want 1 9000 0",
                     ereq[0], eaddr[0], ewe[0]);
        end
        step();
        step();
        ext_ack   = 1'b1;
        ext_rdata = 8'hC3;
        step();
        ext_ack = 1'b0;
        checks++;
        if (rdy[0] !== 1'b1 || din[0] !== 8'hC3 || ereq[0] !== 1'b0) begin
            errors++;
            $display("FAIL ext_read_ack: ready=%b data_in=%h ext_req=%b, want 1 c3 0",
                     rdy[0], din[0], ereq[0]);
        end
        step();
        checks++;
        if (rdy[0] !== 1'b0 || din[0] !== 8'hC3) begin
            errors++;
            $display("FAIL ext_read_after: ready=%b data_in=%h, want 0 c3", rdy[0], din[0]);
        end
    endtask

    task automatic test_ext_timeout();
        int   high;
        logic got;
        logic attr_ok;
        high    = 0;
        got     = 1'b0;
        attr_ok = 1'b1;
        issue(16'hFFFC, 8'h11, 1'b1);
        step();
        mem_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rdy[0]) begin
                got = 1'b1;
                break;
            end
            if (ereq[0]) begin
                high++;
                if (ewe[0] !== 1'b1 || ewd[0] !== 8'h11 || eaddr[0] !== 16'hFFFC) attr_ok = 1'b0;
            end
            step();
        end
        checks++;
        if (got !== 1'b1 || high != 16) begin
            errors++;
            $display("FAIL ext_timeout_len: ready_seen=%b ext_req_cycles=%0d, want 1 16", got, high);
        end
        checks++;
        if (attr_ok !== 1'b1) begin
            errors++;
            $display("FAIL ext_write_attrs: unstable or wrong ext_we/ext_wdata/ext_addr (want 1 11 fffc)");
        end
        checks++;
        if (din[0] !== 8'hC3 || ereq[0] !== 1'b0) begin
            errors++;
            $display("FAIL ext_timeout_resp: data_in=%h ext_req=%b, want c3 0", din[0], ereq[0]);
        end
`ifdef MEM_BUS_RESP_ERR_EN
        checks++;
        if (berr[0] !== 1'b1) begin
            errors++;
            $display("FAIL ext_timeout_bus_error: got %b, want 1", berr[0]);
        end
`endif
        step();
        checks++;
        if (rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ext_timeout_pulse: ready=%b, want 0", rdy[0]);
        end
    endtask

    task automatic test_ext_min_latency();
        logic       r;
        logic [7:0] d;
        issue(16'h8000, 8'h00, 1'b0);
        step();
        mem_req = 1'b0;
        step();
        checks++;
        if (ereq[0] !== 1'b1 || eaddr[0] !== 16'h8000) begin
            errors++;
            $display("FAIL ext_base_req: ext_req=%b ext_addr=%h, want 1 8000", ereq[0], eaddr[0]);
        end
        ext_ack   = 1'b1;
        ext_rdata = 8'h3C;
        step();
        checks++;
        if (rdy[0] !== 1'b1 || din[0] !== 8'h3C) begin
            errors++;
            $display("FAIL ext_min_latency: ready=%b data_in=%h, want 1 3c", rdy[0], din[0]);
        end
        ext_rdata = 8'h99;
        step();
        access1(16'h0123, 8'h00, 1'b0, r, d);
        ext_ack = 1'b0;
        checks++;
        if (r !== 1'b1 || d !== 8'h5A) begin
            errors++;
            $display("FAIL stray_ack_ignored: ready=%b data_in=%h, want 1 5a", r, d);
        end
    endtask

    task automatic test_reset_ext();
        logic bad;
        issue(16'hA000, 8'h00, 1'b0);
        step();
        mem_req = 1'b0;
        step();
        resetb = 1'b0;
        step();
        checks++;
        if (ereq[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ext: ext_req=%b ready=%b, want 0 0", ereq[0], rdy[0]);
        end
        resetb = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rdy[0] !== 1'b0 || ereq[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ext_quiet: activity=%b, want 0", bad);
        end
    endtask

    task automatic test_reset_ram();
        logic got;
        do_reset();
        issue(16'h0200, 8'h33, 1'b1);
        step();
        mem_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rdy[2]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL w2_write_ready: ready_seen=%b, want 1", got);
        end
        step();
        issue(16'h0200, 8'h77, 1'b1);
        step();
        mem_req = 1'b0;
        step();
        resetb = 1'b0;
        step();
        checks++;
        if (rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ram: ready=%b, want 0", rdy[2]);
        end
        resetb = 1'b1;
        step();
        issue(16'h0200, 8'h00, 1'b0);
        step();
        mem_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rdy[2]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (got !== 1'b1 || din[2] !== 8'h33) begin
            errors++;
            $display("FAIL reset_mid_ram_unchanged: ready_seen=%b data_in=%h, want 1 33", got, din[2]);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step();
        test_reset();
        test_ram_rw();
        test_unmapped();
        test_wait_states();
        test_ext_read();
        test_ext_timeout();
        test_ext_min_latency();
        test_reset_ext();
        test_reset_ram();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
